ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register for the 64-bit RISC-V pipeline. It consumes the ID/EX register outputs and forwards operands from EX/MEM and MEM/WB. It executes ALU ops, resolves branches and registers the results into EX/MEM. It also contains an optional iterative multiplier that stalls the front end while busy.

Parameters:
XLEN, 64, datapath width
MUL_CYCLES, 64, multiplier iterations (one bit per cycle)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemToReg, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUSrc  input  1 each  control from ID/EX
ID_EX_ALUOp  input  2  00 add, 01 branch, 10 R-type, 11 M-ext
ID_EX_PC_out, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_ImmData  input  XLEN each  operands and PC
ID_EX_RS1, ID_EX_RS2, ID_EX_RD  input  5 each  register indices
ID_EX_Funct  input  4  {funct7[5], funct3}
MEM_WB_RegWrite  input  1  writeback enable
MEM_WB_RD  input  5  writeback index
MEM_WB_WriteData  input  XLEN  writeback value
EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemToReg, EX_MEM_MemWrite  output  1 each  registered control
EX_MEM_ALUResult, EX_MEM_WriteData  output  XLEN each  registered result and forwarded rs2
EX_MEM_RD  output  5  registered destination
EX_MEM_PCSrc  output  1  registered branch-taken
EX_MEM_BranchTarget  output  XLEN  registered PC + (Imm << 1)
Stall  output  1  combinational; upstream holds PC, IF/ID and ID/EX while 1

Behaviour:
- Reset is asynchronous and active-high. It clears every EX_MEM_* output to 0, forces the multiplier FSM to IDLE and clears the counter. Stall reads 0 in IDLE with no M-ext op.
- Forwarding for A (RS1) and B (RS2):
  - Source EX/MEM if EX_MEM_RegWrite, EX_MEM_RD != 0, EX_MEM_RD == RSx and !EX_MEM_MemRead.
  - Else source MEM/WB if MEM_WB_RegWrite, MEM_WB_RD != 0 and MEM_WB_RD == RSx.
  - Else use ReadDatax. EX/MEM has priority. x0 is never forwarded.
- Operand B selection: ALUSrc=1 uses ImmData; otherwise forwarded B. EX_MEM_WriteData always takes forwarded B.
- ALU results:
  - ALUOp 00: A+B.
  - ALUOp 01: A-B.
  - ALUOp 10, by Funct: 0000 add, 1000 sub, 0111 and, 0110 or, 0001 sll (B[5:0]), 0101 srl (B[5:0]). Other codes give add.
  - All arithmetic is modulo 2^64.
- Branch: taken = Branch & cond. Funct[2:0] 000 beq (A==B), 001 bne, 100 blt (signed). Others are not taken. Target = ID_EX_PC_out + (ImmData << 1).
- Latency: non-multiply ops take 1 cycle from ID/EX to EX/MEM.
- Squash: if EX_MEM_PCSrc==1 at a rising edge, the instruction in EX is wrong-path. EX/MEM then loads a bubble: all control 0, PCSrc 0, RD 0. Flushing IF/ID and ID/EX is upstream's job.
- Bubble means RegWrite, MemRead, MemToReg, MemWrite and PCSrc are 0. Data fields may hold anything.
- Multiplier FSM, IDLE/BUSY/DONE (only with the macro):
  - IDLE: if ALUOp==11 and Funct[2:0]==000 and not squashed, then Stall=1. On the edge: latch A/B, clear the product and counter, load a bubble into EX/MEM, go to BUSY.
  - BUSY: Stall=1 and EX/MEM loads bubbles. Shift-add one multiplier bit per cycle. After MUL_CYCLES iterations go to DONE.
  - DONE: Stall=0. EX/MEM latches the low XLEN product bits with the held ID/EX control. Go to IDLE.
  - Total EX occupancy is MUL_CYCLES+2 cycles. Forwarded operands are sampled once, at the IDLE edge.
- Reset mid-BUSY aborts the multiply: FSM goes to IDLE, Stall drops to 0 and no result is written.
- ALUOp 11 with Funct[2:0] != 000 executes as add without stalling.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: the multiplier FSM above is built and ALUOp 11 mul stalls as specified.
- Undefined: no FSM or counter is built. Stall is tied to 0 and ALUOp 11 executes as add in one cycle.

Test Plan:
- Back-to-back dependency: add x5=3+4, then add x6=x5+x5 with ReadData1/2=0 -> second EX_MEM_ALUResult=14 via EX/MEM forwarding.
- MEM/WB forwarding with x0 guard: MEM_WB_RD=0, MEM_WB_WriteData=99, RS1=0, ReadData1=0 -> A stays 0. Repeat with MEM_WB_RD=RS1=7 -> A=99.
- beq taken, A=B=5, PC=0x100, Imm=8: EX_MEM_PCSrc=1, Target=0x110. Next instruction (add, RegWrite=1) -> EX/MEM bubble with RegWrite=0.
- Load followed by user: EX_MEM_MemRead=1 and EX_MEM_RD==RS1 -> no EX/MEM forward; register or MEM/WB value used.
- With EX_MUL_EN: mul A=0xFFFF_FFFF, B=0x1_0000_0001 -> Stall high for 65 cycles, then EX_MEM_ALUResult=0xFFFF_FFFF_FFFF_FFFF. Bubbles are in EX/MEM meanwhile.
- Reset asserted at BUSY cycle 20 -> all outputs 0 immediately, Stall=0. A new mul after reset completes correctly.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: forwarding, ALU, branch resolve, squash.
// Define EX_MUL_EN to build the iterative shift-add multiplier that stalls the front end.
module ex_mem_stage #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ID_EX_RegWrite,
  input  logic            ID_EX_MemRead,
  input  logic            ID_EX_MemToReg,
  input  logic            ID_EX_MemWrite,
  input  logic            ID_EX_Branch,
  input  logic            ID_EX_ALUSrc,
  input  logic [1:0]      ID_EX_ALUOp,
  input  logic [XLEN-1:0] ID_EX_PC_out,
  input  logic [XLEN-1:0] ID_EX_ReadData1,
  input  logic [XLEN-1:0] ID_EX_ReadData2,
  input  logic [XLEN-1:0] ID_EX_ImmData,
  input  logic [4:0]      ID_EX_RS1,
  input  logic [4:0]      ID_EX_RS2,
  input  logic [4:0]      ID_EX_RD,
  input  logic [3:0]      ID_EX_Funct,
  input  logic            MEM_WB_RegWrite,
  input  logic [4:0]      MEM_WB_RD,
  input  logic [XLEN-1:0] MEM_WB_WriteData,
  output logic            EX_MEM_RegWrite,
  output logic            EX_MEM_MemRead,
  output logic            EX_MEM_MemToReg,
  output logic            EX_MEM_MemWrite,
  output logic [XLEN-1:0] EX_MEM_ALUResult,
  output logic [XLEN-1:0] EX_MEM_WriteData,
  output logic [4:0]      EX_MEM_RD,
  output logic            EX_MEM_PCSrc,
  output logic [XLEN-1:0] EX_MEM_BranchTarget,
  output logic            Stall
);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] mul_result;
  logic            squash;
  logic            br_taken;
  logic            mul_bubble;
  logic            mul_done;

  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [XLEN-1:0] alu_f(input logic [1:0] op, input logic [3:0] funct,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = a + b;
    if (op == 2'b01) begin
      r = a - b;
    end else if (op == 2'b10) begin
      case (funct)
        4'b1000: r = a - b;
        4'b0111: r = a & b;
        4'b0110: r = a | b;
        4'b0001: r = a << b[5:0];
        4'b0101: r = a >> b[5:0];
        default: r = a + b;
      endcase
    end
    return r;
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      default: return 1'b0;
    endcase
  endfunction

  // EX/MEM results are newer than MEM/WB; a load in EX/MEM has no value yet.
  always_comb begin
    fwd_a = ID_EX_ReadData1;
    if (fwd_hit(EX_MEM_RegWrite && !EX_MEM_MemRead, EX_MEM_RD, ID_EX_RS1))
      fwd_a = EX_MEM_ALUResult;
    else if (fwd_hit(MEM_WB_RegWrite, MEM_WB_RD, ID_EX_RS1))
      fwd_a = MEM_WB_WriteData;
    fwd_b = ID_EX_ReadData2;
    if (fwd_hit(EX_MEM_RegWrite && !EX_MEM_MemRead, EX_MEM_RD, ID_EX_RS2))
      fwd_b = EX_MEM_ALUResult;
    else if (fwd_hit(MEM_WB_RegWrite, MEM_WB_RD, ID_EX_RS2))
      fwd_b = MEM_WB_WriteData;
  end

  assign op_b      = ID_EX_ALUSrc ? ID_EX_ImmData : fwd_b;
  assign alu_res   = alu_f(ID_EX_ALUOp, ID_EX_Funct, fwd_a, op_b);
  assign br_taken  = ID_EX_Branch && branch_cond(ID_EX_Funct[2:0], fwd_a, fwd_b);
  assign br_target = ID_EX_PC_out + (ID_EX_ImmData << 1);
  assign squash    = EX_MEM_PCSrc;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  mul_state_t      mul_state;
  logic [CNT_W-1:0] mul_cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] prod;
  logic            mul_start;

  assign mul_start  = (mul_state == MUL_IDLE) && (ID_EX_ALUOp == 2'b11) &&
                      (ID_EX_Funct[2:0] == 3'b000) && !squash;
  assign mul_bubble = mul_start || (mul_state == MUL_BUSY);
  assign mul_done   = (mul_state == MUL_DONE);
  assign mul_result = prod;
  // Gated by reset so an abort releases the front end immediately.
  assign Stall      = mul_bubble && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_state <= MUL_IDLE;
      mul_cnt   <= '0;
    end else begin
      case (mul_state)
        MUL_IDLE: if (mul_start) begin
          mul_state <= MUL_BUSY;
          mul_cnt   <= '0;
        end
        MUL_BUSY: begin
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == CNT_W'(MUL_CYCLES - 1)) mul_state <= MUL_DONE;
        end
        default: mul_state <= MUL_IDLE;
      endcase
    end
  end

  // Shift-add datapath: one multiplier bit retired per BUSY cycle.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand  <= fwd_a;
      mplier <= op_b;
      prod   <= '0;
    end else if (mul_state == MUL_BUSY) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign mul_bubble = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = '0;
  assign Stall      = 1'b0;
`endif

  // EX -> EX/MEM register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_MEM_RegWrite     <= 1'b0;
      EX_MEM_MemRead      <= 1'b0;
      EX_MEM_MemToReg     <= 1'b0;
      EX_MEM_MemWrite     <= 1'b0;
      EX_MEM_PCSrc        <= 1'b0;
      EX_MEM_RD           <= 5'd0;
      EX_MEM_ALUResult    <= '0;
      EX_MEM_WriteData    <= '0;
      EX_MEM_BranchTarget <= '0;
    end else begin
      EX_MEM_ALUResult    <= mul_done ? mul_result : alu_res;
      EX_MEM_WriteData    <= fwd_b;
      EX_MEM_BranchTarget <= br_target;
      if (squash || mul_bubble) begin
        EX_MEM_RegWrite <= 1'b0;
        EX_MEM_MemRead  <= 1'b0;
        EX_MEM_MemToReg <= 1'b0;
        EX_MEM_MemWrite <= 1'b0;
        EX_MEM_PCSrc    <= 1'b0;
        EX_MEM_RD       <= 5'd0;
      end else begin
        EX_MEM_RegWrite <= ID_EX_RegWrite;
        EX_MEM_MemRead  <= ID_EX_MemRead;
        EX_MEM_MemToReg <= ID_EX_MemToReg;
        EX_MEM_MemWrite <= ID_EX_MemWrite;
        EX_MEM_PCSrc    <= br_taken;
        EX_MEM_RD       <= ID_EX_RD;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the EX/MEM register.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        rw, mr, m2r, mw, br, alusrc;
  logic [1:0]  aluop;
  logic [63:0] pc, rd1, rd2, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  funct;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_wd;
  logic        o_rw, o_mr, o_m2r, o_mw, o_pcsrc, stall;
  logic [63:0] o_res, o_wd, o_tgt;
  logic [4:0]  o_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset),
    .ID_EX_RegWrite(rw), .ID_EX_MemRead(mr), .ID_EX_MemToReg(m2r), .ID_EX_MemWrite(mw),
    .ID_EX_Branch(br), .ID_EX_ALUSrc(alusrc), .ID_EX_ALUOp(aluop),
    .ID_EX_PC_out(pc), .ID_EX_ReadData1(rd1), .ID_EX_ReadData2(rd2), .ID_EX_ImmData(imm),
    .ID_EX_RS1(rs1), .ID_EX_RS2(rs2), .ID_EX_RD(rd), .ID_EX_Funct(funct),
    .MEM_WB_RegWrite(wb_we), .MEM_WB_RD(wb_rd), .MEM_WB_WriteData(wb_wd),
    .EX_MEM_RegWrite(o_rw), .EX_MEM_MemRead(o_mr), .EX_MEM_MemToReg(o_m2r),
    .EX_MEM_MemWrite(o_mw), .EX_MEM_ALUResult(o_res), .EX_MEM_WriteData(o_wd),
    .EX_MEM_RD(o_rd), .EX_MEM_PCSrc(o_pcsrc), .EX_MEM_BranchTarget(o_tgt), .Stall(stall)
  );

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic        alusrc;
    logic        br;
    logic [63:0] pc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [63:0] res;
    logic        tk;
    logic [63:0] tgt;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    {rw, mr, m2r, mw, br, alusrc} = '0;
    aluop = 2'b00; funct = 4'h0;
    pc = '0; rd1 = '0; rd2 = '0; imm = '0;
    rs1 = '0; rs2 = '0; rd = '0;
    wb_we = 1'b0; wb_rd = '0; wb_wd = '0;
  endtask

  task automatic drive_alu(input logic [1:0] op, input logic [3:0] f, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d,
                           input logic [63:0] a, input logic [63:0] b);
    drive_nop();
    aluop = op; funct = f; rs1 = s1; rs2 = s2; rd = d; rd1 = a; rd2 = b; rw = 1'b1;
  endtask

  // Runs one multiply to completion, checking the stall length and bubbles.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
    int n;
    int bad;
    logic [63:0] exp_p;
    exp_p = a * b;
    drive_alu(2'b11, 4'h0, 5'd0, 5'd0, d, a, b);
    #1;
    n = 0;
    bad = 0;
    while (stall && n < 200) begin
      n++;
      step();
      if (o_rw || o_rd != 5'd0) bad++;
    end
    chk("mul_stall_cycles", 64'(n), 64'd65);
    chk("mul_bubbles", 64'(bad), 64'd0);
    step();
    chk("mul_result", o_res, exp_p);
    chk("mul_regwrite", {63'd0, o_rw}, 64'd1);
    chk("mul_rd", {59'd0, o_rd}, {59'd0, d});
    drive_nop();
  endtask

  function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [3:0] f,
                                          input logic [63:0] a, input logic [63:0] b);
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    case (f)
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0001: return a * (64'd1 << b[5:0]);
      4'b0101: return a / (64'd1 << b[5:0]);
      default: return a + b;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    if (f[2:0] == 3'b000) return a == b;
    if (f[2:0] == 3'b001) return a != b;
    if (f[2:0] == 3'b100) return $signed(a) < $signed(b);
    return 1'b0;
  endfunction

  // Model of what EX/MEM currently holds.
  logic        m_rw, m_mr, m_pcsrc;
  logic [4:0]  m_rd;
  logic [63:0] m_res;

  // Newest value of register rs visible to EX.
  function automatic logic [63:0] reg_value(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0) return rf;
    if (m_rw && !m_mr && m_rd == rs) return m_res;
    if (wb_we && wb_rd == rs) return wb_wd;
    return rf;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a, bf, bsel, e_res, e_tgt;
    logic        sq, e_tk;

    vt[0]  = '{2'b00, 4'h0, 1'b0, 1'b0, 64'h0, 64'd3, 64'd4, 64'd0, 64'd7, 1'b0, 64'h0};
    vt[1]  = '{2'b01, 4'h0, 1'b0, 1'b0, 64'h0, 64'd5, 64'd8, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'h0};
    vt[2]  = '{2'b10, 4'h0, 1'b0, 1'b0, 64'h0, 64'd100, 64'd23, 64'd0, 64'd123, 1'b0, 64'h0};
    vt[3]  = '{2'b10, 4'h8, 1'b0, 1'b0, 64'h0, 64'd0, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
    vt[4]  = '{2'b10, 4'h7, 1'b0, 1'b0, 64'h0, 64'hF0F0, 64'hFF00, 64'd0, 64'hF000, 1'b0, 64'h0};
    vt[5]  = '{2'b10, 4'h6, 1'b0, 1'b0, 64'h0, 64'hF0F0, 64'h0F0F, 64'd0, 64'hFFFF, 1'b0, 64'h0};
    vt[6]  = '{2'b10, 4'h1, 1'b0, 1'b0, 64'h0, 64'd1, 64'd65, 64'd0, 64'd2, 1'b0, 64'h0};
    vt[7]  = '{2'b10, 4'h5, 1'b0, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd1, 1'b0, 64'h0};
    vt[8]  = '{2'b10, 4'h2, 1'b0, 1'b0, 64'h0, 64'd2, 64'd3, 64'd0, 64'd5, 1'b0, 64'h0};
    vt[9]  = '{2'b00, 4'h0, 1'b1, 1'b0, 64'h40, 64'd5, 64'd100, 64'd7, 64'd12, 1'b0, 64'h4E};
    vt[10] = '{2'b01, 4'h0, 1'b0, 1'b1, 64'h200, 64'd5, 64'd6, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h208};
    vt[11] = '{2'b01, 4'h4, 1'b0, 1'b1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd16, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'h320};
    vt[12] = '{2'b01, 4'h4, 1'b0, 1'b1, 64'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd2, 1'b0, 64'h0};
    vt[13] = '{2'b01, 4'h1, 1'b0, 1'b1, 64'h1000, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFC};
    vt[14] = '{2'b01, 4'h2, 1'b0, 1'b1, 64'h10, 64'd7, 64'd7, 64'd1, 64'd0, 1'b0, 64'h12};
    vt[15] = '{2'b01, 4'h0, 1'b0, 1'b0, 64'h10, 64'd7, 64'd7, 64'd1, 64'd0, 1'b0, 64'h12};
    vt[16] = '{2'b11, 4'h1, 1'b0, 1'b0, 64'h0, 64'd40, 64'd2, 64'd0, 64'd42, 1'b0, 64'h0};

    drive_nop();
    reset = 1'b1;
    #1;
    chk("reset_stall", {63'd0, stall}, 64'd0);
    step();
    chk("reset_ctrl", {59'd0, o_rw, o_mr, o_m2r, o_mw, o_pcsrc}, 64'd0);
    chk("reset_rd", {59'd0, o_rd}, 64'd0);
    chk("reset_res", o_res, 64'd0);
    chk("reset_wd", o_wd, 64'd0);
    chk("reset_tgt", o_tgt, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive_nop();
      aluop = vt[i].aluop; funct = vt[i].funct; alusrc = vt[i].alusrc; br = vt[i].br;
      pc = vt[i].pc; rd1 = vt[i].a; rd2 = vt[i].b; imm = vt[i].imm;
      rw = 1'b1; rd = 5'(i + 1);
      step();
      chk($sformatf("vec%0d_res", i), o_res, vt[i].res);
      chk($sformatf("vec%0d_pcsrc", i), {63'd0, o_pcsrc}, {63'd0, vt[i].tk});
      chk($sformatf("vec%0d_tgt", i), o_tgt, vt[i].tgt);
      chk($sformatf("vec%0d_wd", i), o_wd, vt[i].b);
      chk($sformatf("vec%0d_rd", i), {59'd0, o_rd}, 64'(i + 1));
      chk($sformatf("vec%0d_stall", i), {63'd0, stall}, 64'd0);
      drive_nop();
      step();
    end

    // Back-to-back dependency through EX/MEM
    drive_alu(2'b00, 4'h0, 5'd1, 5'd2, 5'd5, 64'd3, 64'd4);
    step();
    chk("dep_first", o_res, 64'd7);
    drive_alu(2'b00, 4'h0, 5'd5, 5'd5, 5'd6, 64'd0, 64'd0);
    step();
    chk("dep_fwd_exmem", o_res, 64'd14);
    chk("dep_fwd_wd", o_wd, 64'd7);

    // MEM/WB forwarding, x0 never forwarded
    drive_nop();
    step();
    drive_alu(2'b00, 4'h0, 5'd0, 5'd0, 5'd8, 64'd0, 64'd0);
    wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 64'd99;
    step();
    chk("x0_guard", o_res, 64'd0);
    drive_nop();
    step();
    drive_alu(2'b00, 4'h0, 5'd7, 5'd0, 5'd8, 64'd0, 64'd0);
    wb_we = 1'b1; wb_rd = 5'd7; wb_wd = 64'd99;
    step();
    chk("memwb_fwd", o_res, 64'd99);

    // Taken beq, then squashed follower
    drive_alu(2'b01, 4'h0, 5'd0, 5'd0, 5'd0, 64'd5, 64'd5);
    rw = 1'b0; br = 1'b1; pc = 64'h100; imm = 64'd8;
    step();
    chk("beq_pcsrc", {63'd0, o_pcsrc}, 64'd1);
    chk("beq_tgt", o_tgt, 64'h110);
    drive_alu(2'b00, 4'h0, 5'd0, 5'd0, 5'd9, 64'd1, 64'd1);
    step();
    chk("squash_rw", {63'd0, o_rw}, 64'd0);
    chk("squash_rd", {59'd0, o_rd}, 64'd0);
    chk("squash_pcsrc", {63'd0, o_pcsrc}, 64'd0);

    // Load followed by a user: no EX/MEM forward
    drive_alu(2'b00, 4'h0, 5'd0, 5'd0, 5'd3, 64'd50, 64'd0);
    mr = 1'b1;
    step();
    chk("load_memread", {63'd0, o_mr}, 64'd1);
    drive_alu(2'b00, 4'h0, 5'd3, 5'd0, 5'd4, 64'd11, 64'd0);
    step();
    chk("load_use_regfile", o_res, 64'd11);
    drive_alu(2'b00, 4'h0, 5'd0, 5'd0, 5'd3, 64'd50, 64'd0);
    mr = 1'b1;
    step();
    drive_alu(2'b00, 4'h0, 5'd3, 5'd0, 5'd4, 64'd11, 64'd0);
    wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 64'd22;
    step();
    chk("load_use_memwb", o_res, 64'd22);
    drive_nop();
    step();

`ifdef EX_MUL_EN
    run_mul(64'hFFFF_FFFF, 64'h1_0000_0001, 5'd10);
    step();
    // Abort during BUSY
    drive_alu(2'b11, 4'h0, 5'd0, 5'd0, 5'd11, 64'd7, 64'd9);
    repeat (21) step();
    chk("busy_stall", {63'd0, stall}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_stall", {63'd0, stall}, 64'd0);
    chk("abort_ctrl", {59'd0, o_rw, o_mr, o_m2r, o_mw, o_pcsrc}, 64'd0);
    chk("abort_res", o_res, 64'd0);
    step();
    reset = 1'b0;
    run_mul(64'd123456789, 64'd987654321, 5'd12);
    step();
`else
    drive_alu(2'b11, 4'h0, 5'd0, 5'd0, 5'd10, 64'hFFFF_FFFF, 64'h1_0000_0001);
    #1;
    chk("mul_off_stall", {63'd0, stall}, 64'd0);
    step();
    chk("mul_off_add", o_res, 64'h1_FFFF_FFFF + 64'd1);
    drive_nop();
    step();
`endif

    // Randomized run against the model
    drive_nop();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_rw = 1'b0; m_mr = 1'b0; m_pcsrc = 1'b0; m_rd = '0; m_res = '0;
    for (int c = 0; c < 400; c++) begin
      rw = 1'($urandom); mr = ($urandom_range(0, 3) == 0); m2r = 1'($urandom);
      mw = 1'($urandom); br = ($urandom_range(0, 3) == 0); alusrc = 1'($urandom);
      aluop = 2'($urandom); funct = 4'($urandom);
      if (aluop == 2'b10 && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 5))
          0: funct = 4'h0;
          1: funct = 4'h8;
          2: funct = 4'h7;
          3: funct = 4'h6;
          4: funct = 4'h1;
          default: funct = 4'h5;
        endcase
      end
`ifdef EX_MUL_EN
      if (aluop == 2'b11 && funct[2:0] == 3'b000) funct[0] = 1'b1;
`endif
      pc = {$urandom, $urandom}; imm = {$urandom, $urandom};
      rd1 = {$urandom, $urandom};
      rd2 = ($urandom_range(0, 3) == 0) ? rd1 : {$urandom, $urandom};
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_wd = {$urandom, $urandom};
      sq = m_pcsrc;
      a = reg_value(rs1, rd1);
      bf = reg_value(rs2, rd2);
      bsel = alusrc ? imm : bf;
      e_res = ref_alu(aluop, funct, a, bsel);
      e_tk = br && ref_taken(funct, a, bf);
      e_tgt = pc + imm * 64'd2;
      step();
      if (sq) begin
        chk("rnd_squash_ctrl", {59'd0, o_rw, o_mr, o_m2r, o_mw, o_pcsrc}, 64'd0);
        chk("rnd_squash_rd", {59'd0, o_rd}, 64'd0);
      end else begin
        chk("rnd_ctrl", {59'd0, o_rw, o_mr, o_m2r, o_mw, o_pcsrc},
            {59'd0, rw, mr, m2r, mw, e_tk});
        chk("rnd_rd", {59'd0, o_rd}, {59'd0, rd});
        chk("rnd_res", o_res, e_res);
        chk("rnd_wd", o_wd, bf);
        chk("rnd_tgt", o_tgt, e_tgt);
      end
      chk("rnd_stall", {63'd0, stall}, 64'd0);
      m_rw = sq ? 1'b0 : rw;
      m_mr = sq ? 1'b0 : mr;
      m_rd = sq ? 5'd0 : rd;
      m_pcsrc = sq ? 1'b0 : e_tk;
      m_res = e_res;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
